mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-input `mux8` datapath between eight requesters. It drives the mux select, hands each requester a one-hot grant, and enforces a bounded hold time so no requester can monopolise the shared path. It sits beside the `mux8` instance in the multicycle core. Its `sel` output connects directly to the mux `sel` port.

---
 rtl/mux8_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared mux8 datapath: one-hot registered grant, mux select,
// and bounded hold time with preemption when other requesters are waiting.
`timescale 1ns / 1ps

module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       busy_o,
    output logic       preempt_o
);

    localparam bit         PreemptEn = (HOLD_MAX != 0);
    localparam logic [7:0] HoldLast  = 8'(HOLD_MAX - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;

    logic [7:0] others;
    logic       owner_req;
    logic       timeout;
    logic [2:0] next_ptr;
    logic [2:0] win_idle;
    logic [2:0] win_hand;

    // First set bit of mask scanning upward from start, wrapping modulo 8.
    function automatic logic [2:0] arbitrate(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        arbitrate = start;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (mask[idx]) begin
                arbitrate = idx;
            end
        end
    endfunction

    assign others    = req_i & ~gnt_q;
    assign owner_req = |(req_i & gnt_q);
    assign timeout   = PreemptEn && (hold_q == HoldLast) && (|others);
    assign next_ptr  = sel_q + 3'd1;
    assign win_idle  = arbitrate(req_i, ptr_q);
    assign win_hand  = arbitrate(others, next_ptr);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d = StGrant;
                    gnt_d   = 8'b1 << win_idle;
                    sel_d   = win_idle;
                    hold_d  = 8'd0;
                end
            end
            StGrant: begin
                if (!owner_req || timeout) begin
                    ptr_d = next_ptr;
                    if (|others) begin
                        gnt_d     = 8'b1 << win_hand;
                        sel_d     = win_hand;
                        hold_d    = 8'd0;
                        // Owner still requesting means the release was forced.
                        preempt_d = owner_req;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 8'd0;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            gnt_q     <= 8'd0;
            sel_q     <= 3'd0;
            ptr_q     <= 3'd0;
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = (state_q == StGrant);
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus randomized traffic, all checked
// against an integer-level round-robin reference model.
`timescale 1ns / 1ps

module tb_mux8_rr_arbiter;

    localparam int HM = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       preempt;

    int n_cmp;
    int n_fail;

    // Reference model state: owner index (-1 = idle), pointer, hold count, age of grant.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;
    int m_age;
    bit m_pre;

    mux8_rr_arbiter #(
        .HOLD_MAX(HM)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .sel_o    (sel),
        .busy_o   (busy),
        .preempt_o(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [7:0] m, input int p);
        for (int i = 0; i < 8; i++) begin
            if (m[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
        m_age   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] oth;
        bit         own;
        bit         to;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            if (r != 8'd0) begin
                m_owner = arb(r, m_ptr);
                m_sel   = m_owner;
                m_hold  = 0;
                m_age   = 0;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            own = r[m_owner];
            to  = (HM != 0) && (m_hold == HM - 1) && (oth != 8'd0);
            if (!own || to) begin
                m_ptr = (m_owner + 1) % 8;
                if (oth != 8'd0) begin
                    m_owner = arb(oth, m_ptr);
                    m_sel   = m_owner;
                    m_hold  = 0;
                    m_age   = 0;
                    m_pre   = own;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
                m_age++;
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] eg;
        eg = 8'd0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        cmp("gnt", gnt, eg);
        cmp("sel", {5'd0, sel}, 8'(m_sel));
        cmp("busy", {7'd0, busy}, {7'd0, (m_owner >= 0)});
        cmp("preempt", {7'd0, preempt}, {7'd0, m_pre});
    endtask

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_model();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp("rst_gnt", gnt, 8'h00);
        cmp("rst_sel", {5'd0, sel}, 8'h00);
        cmp("rst_busy", {7'd0, busy}, 8'h00);
        cmp("rst_preempt", {7'd0, preempt}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] prev_gnt;
        logic [7:0] cur;
        int         order[$];

        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;

        // Single request
        for (int i = 0; i < 3; i++) begin
            cycle(8'h20);
            cmp("single_gnt", gnt, 8'h20);
            cmp("single_sel", {5'd0, sel}, 8'd5);
        end
        cycle(8'h00);
        cycle(8'h00);
        cmp("single_idle_gnt", gnt, 8'h00);
        cmp("single_idle_sel", {5'd0, sel}, 8'd5);

        // Reset mid-operation with all requesting, then round-robin from index 0
        cycle(8'hFF);
        cycle(8'hFF);
        req = 8'hFF;
        async_reset();
        prev_gnt = 8'h00;
        for (int i = 0; i < 20; i++) begin
            cur = 8'hFF;
            if (m_owner >= 0 && m_age == 1) cur[m_owner] = 1'b0;
            cycle(cur);
            if (i == 0) cmp("first_after_reset", gnt, 8'h01);
            if (i > 0) cmp("rr_no_idle", {7'd0, busy}, 8'h01);
            if (gnt != prev_gnt && gnt != 8'h00) order.push_back(int'(sel));
            prev_gnt = gnt;
        end
        cmp("rr_count", {7'd0, (order.size() >= 9)}, 8'h01);
        for (int i = 0; i < 9; i++) begin
            if (i < order.size()) cmp("rr_order", 8'(order[i]), 8'(i % 8));
        end

        // Wrap-around priority
        req = 8'h00;
        async_reset();
        cycle(8'h40);
        cmp("wrap_own6", gnt, 8'h40);
        cycle(8'h03);
        cmp("wrap_next0", {5'd0, sel}, 8'd0);
        cycle(8'h43);
        cycle(8'h42);
        cmp("wrap_next1", {5'd0, sel}, 8'd1);
        cycle(8'h00);
        cycle(8'h00);

        // Preemption
        async_reset();
        cycle(8'h04);
        for (int i = 0; i < 3; i++) begin
            cycle(8'h24);
            cmp("pre_hold_gnt", gnt, 8'h04);
            cmp("pre_hold_pulse", {7'd0, preempt}, 8'h00);
        end
        cycle(8'h24);
        cmp("pre_switch_gnt", gnt, 8'h20);
        cmp("pre_switch_pulse", {7'd0, preempt}, 8'h01);
        cycle(8'h24);
        cmp("pre_pulse_once", {7'd0, preempt}, 8'h00);
        for (int i = 0; i < 8; i++) cycle(8'h24);

        // Saturation without contention
        cycle(8'h00);
        cycle(8'h00);
        for (int i = 0; i < 300; i++) begin
            cycle(8'h08);
            cmp("sat_gnt", gnt, 8'h08);
            cmp("sat_pulse", {7'd0, preempt}, 8'h00);
        end

        // Randomized traffic
        cur = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            cur = cur ^ 8'($urandom & $urandom & $urandom);
            if (m_owner >= 0 && m_age >= 2 && $urandom_range(0, 3) == 0) cur[m_owner] = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                req = cur;
                async_reset();
            end else begin
                cycle(cur);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
